mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 49 ++++
 rtl/mult_div_unit_iter.sv | 71 +++++++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared ALU definitions: the 5-bit operation codes produced by the ALU
// control block and consumed by the multiply/divide unit, plus small helper
// functions that classify those codes.
// No ports (package).
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

  // ALU operation codes driven on iControlSignal by the ALU control block
  localparam logic [4:0] OPADD   = 5'd0;
  localparam logic [4:0] OPSUB   = 5'd1;
  localparam logic [4:0] OPAND   = 5'd2;
  localparam logic [4:0] OPOR    = 5'd3;
  localparam logic [4:0] OPMULT  = 5'd16;
  localparam logic [4:0] OPMULTU = 5'd17;
  localparam logic [4:0] OPDIV   = 5'd18;
  localparam logic [4:0] OPDIVU  = 5'd19;
  localparam logic [4:0] OPMADD  = 5'd20;
  localparam logic [4:0] OPMADDU = 5'd21;
  localparam logic [4:0] OPMSUB  = 5'd22;
  localparam logic [4:0] OPMSUBU = 5'd23;
  localparam logic [4:0] OPMTHI  = 5'd24;
  localparam logic [4:0] OPMTLO  = 5'd25;

  // Operations that run through the 32-cycle shift core
  function automatic logic isIterativeOp(input logic [4:0] op);
    return op inside {OPMULT, OPMULTU, OPDIV, OPDIVU,
                      OPMADD, OPMADDU, OPMSUB, OPMSUBU};
  endfunction

  function automatic logic isDivOp(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  // Signed variants need magnitude conversion before and sign fix after
  function automatic logic isSignedOp(input logic [4:0] op);
    return op inside {OPMULT, OPDIV, OPMADD, OPMSUB};
  endfunction

  function automatic logic isMaddOp(input logic [4:0] op);
    return (op == OPMADD) || (op == OPMADDU);
  endfunction

  function automatic logic isMsubOp(input logic [4:0] op);
    return (op == OPMSUB) || (op == OPMSUBU);
  endfunction

endpackage

// File: rtl/mult_div_unit_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter_core
// Unsigned one-bit-per-cycle engine shared by multiply and divide.
//   multiply : shift-add, hi accumulates, lo holds the multiplier and
//              fills with product bits; {hi,lo} = opd * lo after 32 steps
//   divide   : restoring shift-subtract, lo holds the dividend and fills
//              with quotient bits; hi ends as the remainder
// Ports:
//   iCLK, iRST  clock and synchronous active-high reset
//   iLoad       load hi=0, lo=iLoadLo, opd=iLoadOpd
//   iStep       perform one iteration
//   iDivMode    1 = divide step, 0 = multiply step
//   iLoadLo     multiplier (multiply) or dividend (divide), magnitude
//   iLoadOpd    multiplicand (multiply) or divisor (divide), magnitude
//   oHi, oLo    working registers; final product / remainder:quotient
// ---------------------------------------------------------------------------
module mdu_iter_core (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iLoad,
  input  logic        iStep,
  input  logic        iDivMode,
  input  logic [31:0] iLoadLo,
  input  logic [31:0] iLoadOpd,
  output logic [31:0] oHi,
  output logic [31:0] oLo
);

  logic [31:0] hiReg, loReg, opdReg;
  logic [32:0] mulSum;
  logic [32:0] divShifted;
  logic [33:0] divDiff;

  // One iteration of each algorithm; the divide compare uses a spare top
  // bit so a negative trial difference shows up as divDiff[33]
  always_comb begin
    mulSum     = {1'b0, hiReg} + (loReg[0] ? {1'b0, opdReg} : 33'd0);
    divShifted = {hiReg, loReg[31]};
    divDiff    = {1'b0, divShifted} - {2'b00, opdReg};
  end

  // Working registers: load on request, otherwise advance one bit per step
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hiReg  <= '0;
      loReg  <= '0;
      opdReg <= '0;
    end else if (iLoad) begin
      hiReg  <= '0;
      loReg  <= iLoadLo;
      opdReg <= iLoadOpd;
    end else if (iStep) begin
      if (iDivMode) begin
        if (!divDiff[33]) begin
          hiReg <= divDiff[31:0];
          loReg <= {loReg[30:0], 1'b1};
        end else begin
          hiReg <= divShifted[31:0];
          loReg <= {loReg[30:0], 1'b0};
        end
      end else begin
        hiReg <= mulSum[32:1];
        loReg <= {mulSum[0], loReg[31:1]};
      end
    end
  end

  assign oHi = hiReg;
  assign oLo = loReg;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// HI/LO multiply/divide unit. Iterative ops take 34 edges: latch, 32 core
// steps, then a fixup edge that applies signs/accumulation and writes HI/LO.
// MTHI/MTLO write directly in a single edge.
// Ports:
//   iCLK, iRST       clock and synchronous active-high reset
//   iStart           operation request (accepted only when idle)
//   iControlSignal   ALU operation code
//   iA, iB           rs / rt operands
//   oHI, oLO         HI and LO registers
//   oBusy            iterative operation in flight
//   oDone            one-cycle pulse after HI/LO written by an iterative op
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [4:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

  state_e      state, nextState;
  logic [4:0]  opReg;
  logic [31:0] aReg, bReg;
  logic [4:0]  count;
  logic [31:0] hiReg, loReg;
  logic        doneReg;

  logic        accept, mtWrite;
  logic [31:0] aMag, bMag;
  logic [31:0] coreHi, coreLo;
  logic [63:0] coreProd, signedProd, accumResult;
  logic [31:0] fixHi, fixLo;
  logic        prodNeg, quotNeg, remNeg;

  // Request decode: only an idle unit listens to iStart. Signed ops hand
  // the core magnitudes; negating 32'h80000000 yields itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    accept  = (state == IDLE) && iStart && isIterativeOp(iControlSignal);
    mtWrite = (state == IDLE) && iStart &&
              ((iControlSignal == OPMTHI) || (iControlSignal == OPMTLO));
    aMag = (isSignedOp(iControlSignal) && iA[31]) ? -iA : iA;
    bMag = (isSignedOp(iControlSignal) && iB[31]) ? -iB : iB;
  end

  mdu_iter_core uCore (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iLoad    (accept),
    .iStep    (state == CALC),
    .iDivMode (isDivOp(opReg)),
    .iLoadLo  (isDivOp(iControlSignal) ? aMag : bMag),
    .iLoadOpd (isDivOp(iControlSignal) ? bMag : aMag),
    .oHi      (coreHi),
    .oLo      (coreLo)
  );

  // Next-state logic: 32 CALC cycles counted by count, then one FIXUP
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = CALC;
      CALC:    if (count == 5'd31) nextState = FIXUP;
      FIXUP:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Fixup arithmetic on the latched operands. Division by zero bypasses
  // sign correction so HI gets the original signed dividend back.
  always_comb begin
    coreProd    = {coreHi, coreLo};
    prodNeg     = isSignedOp(opReg) && (aReg[31] ^ bReg[31]);
    quotNeg     = prodNeg;
    remNeg      = isSignedOp(opReg) && aReg[31];
    signedProd  = prodNeg ? -coreProd : coreProd;
    accumResult = signedProd;
    fixHi       = hiReg;
    fixLo       = loReg;
    if (isDivOp(opReg)) begin
      if (bReg == 32'd0) begin
        fixHi = aReg;
        fixLo = 32'hFFFF_FFFF;
      end else begin
        fixLo = quotNeg ? -coreLo : coreLo;
        fixHi = remNeg ? -coreHi : coreHi;
      end
    end else begin
      if (isMaddOp(opReg)) begin
        accumResult = {hiReg, loReg} + signedProd;
      end else if (isMsubOp(opReg)) begin
        accumResult = {hiReg, loReg} - signedProd;
      end
      fixHi = accumResult[63:32];
      fixLo = accumResult[31:0];
    end
  end

  // State, operand latches and HI/LO. Reset wins over everything, so an
  // aborted operation never reaches its fixup write.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      opReg   <= '0;
      aReg    <= '0;
      bReg    <= '0;
      count   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      doneReg <= (state == FIXUP);
      if (accept) begin
        opReg <= iControlSignal;
        aReg  <= iA;
        bReg  <= iB;
        count <= '0;
      end else if (state == CALC) begin
        count <= count + 5'd1;
      end
      if (mtWrite) begin
        if (iControlSignal == OPMTHI) hiReg <= iA;
        else                          loReg <= iA;
      end else if (state == FIXUP) begin
        hiReg <= fixHi;
        loReg <= fixLo;
      end
    end
  end

  assign oHI   = hiReg;
  assign oLO   = loReg;
  assign oBusy = (state != IDLE);
  assign oDone = doneReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed and randomized checks of mult_div_unit against a 64-bit
// arithmetic reference model of HI/LO.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic [4:0]  iControlSignal;
  logic [31:0] iA, iB;
  logic [31:0] oHI, oLO;
  logic        oBusy, oDone;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] mHi, mLo;

  logic [4:0]  iterOps [8] = '{OPMULT, OPMULTU, OPDIV, OPDIVU,
                               OPMADD, OPMADDU, OPMSUB, OPMSUBU};

  mult_div_unit dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iStart         (iStart),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .oHI            (oHI),
    .oLO            (oLO),
    .oBusy          (oBusy),
    .oDone          (oDone)
  );

  always #5 iCLK = ~iCLK;

  // One comparison: counts it, and on mismatch counts the failure
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Architectural effect of one accepted request on the model HI/LO
  task automatic refModel(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] prod, acc;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    acc  = {mHi, mLo};
    if (op inside {OPMULT, OPMADD, OPMSUB}) prod = 64'(sa * sb);
    else                                    prod = {32'd0, a} * {32'd0, b};
    case (op)
      OPMULT, OPMULTU: {mHi, mLo} = prod;
      OPMADD, OPMADDU: {mHi, mLo} = acc + prod;
      OPMSUB, OPMSUBU: {mHi, mLo} = acc - prod;
      OPDIV, OPDIVU: begin
        if (b == 32'd0) begin
          mHi = a;
          mLo = 32'hFFFF_FFFF;
        end else if (op == OPDIV) begin
          q   = sa / sb;
          r   = sa % sb;
          mLo = q[31:0];
          mHi = r[31:0];
        end else begin
          mLo = a / b;
          mHi = a % b;
        end
      end
      OPMTHI: mHi = a;
      OPMTLO: mLo = a;
      default: ;
    endcase
  endtask

  // Issue one request, scramble operands after the accepting edge, then
  // check handshake timing and the final HI/LO against the model
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    int n;
    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
    @(negedge iCLK);
    iStart = 1'b0; iA = $urandom; iB = $urandom;
    n = 1;
    if (isIterativeOp(op)) begin
      checkOutput("busyAfterStart", 64'(oBusy), 64'd1);
      while (!oDone && n < 40) begin
        @(negedge iCLK);
        n++;
      end
      checkOutput("doneLatency", 64'(n), 64'd34);
      checkOutput("busyAtDone", 64'(oBusy), 64'd0);
      refModel(op, a, b);
      checkOutput("hiLo", {oHI, oLO}, {mHi, mLo});
      @(negedge iCLK);
      checkOutput("donePulseWidth", 64'(oDone), 64'd0);
    end else begin
      checkOutput("noBusyDone", {62'd0, oBusy, oDone}, 64'd0);
      refModel(op, a, b);
      checkOutput("hiLoDirect", {oHI, oLO}, {mHi, mLo});
    end
  endtask

  initial begin
    int n;
    int doneSeen;
    logic [31:0] ra, rb;
    logic [4:0]  rop;

    iRST = 1'b1; iStart = 1'b0; iControlSignal = OPADD; iA = '0; iB = '0;
    mHi = '0; mLo = '0;
    repeat (2) @(negedge iCLK);
    checkOutput("resetState", {oHI, oLO, 30'd0, oBusy, oDone}, 96'd0);
    iRST = 1'b0;

    // Directed cases with literal expectations
    applyStimulus(OPMULT, -32'sd3, 32'd5);
    checkOutput("multNeg", {oHI, oLO}, 64'hFFFFFFFF_FFFFFFF1);
    applyStimulus(OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("multuMax", {oHI, oLO}, 64'hFFFFFFFE_00000001);
    applyStimulus(OPDIV, -32'sd7, 32'd2);
    checkOutput("divNeg", {oHI, oLO}, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(OPDIVU, 32'd10, 32'd0);
    checkOutput("divuByZero", {oHI, oLO}, 64'h0000000A_FFFFFFFF);
    applyStimulus(OPDIV, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("divOverflow", {oHI, oLO}, 64'h00000000_80000000);
    applyStimulus(OPDIV, -32'sd9, 32'd0);
    checkOutput("divByZeroSigned", {oHI, oLO}, 64'hFFFFFFF7_FFFFFFFF);
    applyStimulus(OPMTHI, 32'd0, 32'd0);
    applyStimulus(OPMTLO, 32'hFFFFFFFF, 32'd0);
    applyStimulus(OPMADD, 32'd1, 32'd1);
    checkOutput("maddCarry", {oHI, oLO}, 64'h00000001_00000000);
    applyStimulus(OPADD, 32'h12345678, 32'h9);

    // Randomized operations, occasionally dividing by zero
    for (int i = 0; i < 24; i++) begin
      rop = iterOps[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      applyStimulus(rop, ra, rb);
    end

    // Requests while busy are ignored, including MTHI
    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = OPMULT; iA = 32'd2; iB = 32'd3;
    @(negedge iCLK);
    iStart = 1'b0;
    n = 1;
    while (!oDone && n < 40) begin
      if (n == 5) begin
        iStart = 1'b1; iControlSignal = OPMULTU; iA = 32'd7; iB = 32'd9;
      end else if (n == 10) begin
        iStart = 1'b1; iControlSignal = OPMTHI; iA = 32'h55;
      end else begin
        iStart = 1'b0;
      end
      @(negedge iCLK);
      n++;
    end
    iStart = 1'b0;
    checkOutput("busyIgnoreLatency", 64'(n), 64'd34);
    checkOutput("busyIgnoreResult", {oHI, oLO}, 64'h00000000_00000006);
    mHi = 32'd0; mLo = 32'd6;
    @(negedge iCLK);
    checkOutput("busyIgnoreIdle", 64'(oBusy), 64'd0);

    // A request on the fixup edge is ignored
    ra = $urandom; rb = $urandom;
    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = OPMULTU; iA = ra; iB = rb;
    @(negedge iCLK);
    iStart = 1'b0;
    n = 1;
    while (n < 33) begin
      @(negedge iCLK);
      n++;
    end
    iStart = 1'b1; iControlSignal = OPMTLO; iA = 32'hDEADBEEF;
    @(negedge iCLK);
    iStart = 1'b0;
    checkOutput("fixupDone", 64'(oDone), 64'd1);
    refModel(OPMULTU, ra, rb);
    checkOutput("fixupIgnore", {oHI, oLO}, {mHi, mLo});
    @(negedge iCLK);
    checkOutput("fixupIdle", {oHI, oLO, 30'd0, oBusy, oDone},
                {mHi, mLo, 32'd0});

    // Reset mid-operation aborts with no write and no done pulse
    applyStimulus(OPMTHI, 32'hA5A5A5A5, 32'd0);
    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = OPMULT; iA = 32'd2; iB = 32'd3;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (9) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    mHi = '0; mLo = '0;
    checkOutput("abortState", {oHI, oLO, 30'd0, oBusy, oDone}, 96'd0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (oDone) doneSeen++;
    end
    checkOutput("abortNoDone", 64'(doneSeen), 64'd0);
    checkOutput("abortHiLo", {oHI, oLO}, {mHi, mLo});

    // Unit still works after the abort
    applyStimulus(OPMSUB, 32'd4, -32'sd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
